issue_queue: RTL and testbench

Out-of-order issue queue sitting directly downstream of the rename stage and upstream of EXE. Accepts one renamed instruction per cycle carrying physical source/destination tags and busy bits. Wakes waiting sources on EXE busy-clear broadcasts and issues the oldest ready entry per cycle. Flushes completely on a branch redirect.

---
 rtl/issue_queue_if.sv | 39 +++
 rtl/issue_queue.sv | 187 ++++++++++++++++++
 tb/tb_issue_queue.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/issue_queue_if.sv
// rtl/issue_queue_if.sv - rename/wake/issue bus for the out-of-order issue queue
interface issue_queue_if #(
  parameter int DEPTH     = 8,
  parameter int TAG_W     = 6,
  parameter int PAYLOAD_W = 104
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                 alloc_valid;
  logic [TAG_W-1:0]     alloc_src_a;
  logic                 alloc_src_a_busy;
  logic [TAG_W-1:0]     alloc_src_b;
  logic                 alloc_src_b_busy;
  logic [TAG_W-1:0]     alloc_dst;
  logic [PAYLOAD_W-1:0] alloc_payload;
  logic                 issue_halt;
  logic                 wake_valid;
  logic [TAG_W-1:0]     wake_tag;
  logic                 issue_stall;
  logic                 flush;
  logic                 issue_valid;
  logic [TAG_W-1:0]     issue_src_a;
  logic [TAG_W-1:0]     issue_src_b;
  logic [TAG_W-1:0]     issue_dst;
  logic [PAYLOAD_W-1:0] issue_payload;
  logic [CW-1:0]        count;

  modport master (
    output alloc_valid, alloc_src_a, alloc_src_a_busy, alloc_src_b, alloc_src_b_busy,
           alloc_dst, alloc_payload, wake_valid, wake_tag, issue_stall, flush,
    input  issue_halt, issue_valid, issue_src_a, issue_src_b, issue_dst, issue_payload, count
  );

  modport slave (
    input  alloc_valid, alloc_src_a, alloc_src_a_busy, alloc_src_b, alloc_src_b_busy,
           alloc_dst, alloc_payload, wake_valid, wake_tag, issue_stall, flush,
    output issue_halt, issue_valid, issue_src_a, issue_src_b, issue_dst, issue_payload, count
  );
endinterface

// File: rtl/issue_queue.sv
// rtl/issue_queue.sv - collapsing out-of-order issue queue; optional ISSUE_FAST_WAKEUP_EN
module issue_queue #(
  parameter int DEPTH     = 8,
  parameter int TAG_W     = 6,
  parameter int PAYLOAD_W = 104
) (
  input logic          CLK,
  input logic          RESET,
  issue_queue_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  logic                 valid_q   [DEPTH];
  logic                 valid_d   [DEPTH];
  logic [TAG_W-1:0]     src_a_q   [DEPTH];
  logic [TAG_W-1:0]     src_a_d   [DEPTH];
  logic [TAG_W-1:0]     src_b_q   [DEPTH];
  logic [TAG_W-1:0]     src_b_d   [DEPTH];
  logic [TAG_W-1:0]     dst_q     [DEPTH];
  logic [TAG_W-1:0]     dst_d     [DEPTH];
  logic                 rdy_a_q   [DEPTH];
  logic                 rdy_a_d   [DEPTH];
  logic                 rdy_b_q   [DEPTH];
  logic                 rdy_b_d   [DEPTH];
  logic [PAYLOAD_W-1:0] payload_q [DEPTH];
  logic [PAYLOAD_W-1:0] payload_d [DEPTH];
  logic                 wk_rdy_a  [DEPTH];
  logic                 wk_rdy_b  [DEPTH];
  logic                 sel_rdy_a [DEPTH];
  logic                 sel_rdy_b [DEPTH];

  logic [CW-1:0]        count_q, count_d;
  logic                 issue_valid_q, issue_valid_d;
  logic [TAG_W-1:0]     issue_src_a_q, issue_src_a_d;
  logic [TAG_W-1:0]     issue_src_b_q, issue_src_b_d;
  logic [TAG_W-1:0]     issue_dst_q, issue_dst_d;
  logic [PAYLOAD_W-1:0] issue_payload_q, issue_payload_d;

  logic                 halt, sel_found, fire, accept, new_rdy_a, new_rdy_b;
  logic [IW-1:0]        sel_idx;
  logic [CW-1:0]        alloc_pos;

  assign halt      = (count_q == CW'(DEPTH));
  assign fire      = sel_found && !bus.issue_stall;
  assign accept    = bus.alloc_valid && !halt && !bus.flush;
  assign alloc_pos = count_q - CW'(fire);
  assign new_rdy_a = !bus.alloc_src_a_busy || (bus.wake_valid && bus.wake_tag == bus.alloc_src_a) ||
                     (bus.alloc_src_a == '0);
  assign new_rdy_b = !bus.alloc_src_b_busy || (bus.wake_valid && bus.wake_tag == bus.alloc_src_b) ||
                     (bus.alloc_src_b == '0);

  // Fold this cycle's wake broadcast into each slot's ready bits; select sees it only in fast mode
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wk_rdy_a[i] = rdy_a_q[i] | (bus.wake_valid && bus.wake_tag == src_a_q[i]);
      wk_rdy_b[i] = rdy_b_q[i] | (bus.wake_valid && bus.wake_tag == src_b_q[i]);
`ifdef ISSUE_FAST_WAKEUP_EN
      sel_rdy_a[i] = wk_rdy_a[i];
      sel_rdy_b[i] = wk_rdy_b[i];
`else
      sel_rdy_a[i] = rdy_a_q[i];
      sel_rdy_b[i] = rdy_b_q[i];
`endif
    end
  end

  // Oldest-first select: the descending scan leaves the lowest ready index
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && sel_rdy_a[i] && sel_rdy_b[i]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  // Next slot contents: wake, collapse above the issued slot, append the allocation, then flush
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_d[i]   = valid_q[i];
      src_a_d[i]   = src_a_q[i];
      src_b_d[i]   = src_b_q[i];
      dst_d[i]     = dst_q[i];
      rdy_a_d[i]   = wk_rdy_a[i];
      rdy_b_d[i]   = wk_rdy_b[i];
      payload_d[i] = payload_q[i];
    end
    if (fire) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (IW'(i) >= sel_idx) begin
          valid_d[i]   = valid_q[i+1];
          src_a_d[i]   = src_a_q[i+1];
          src_b_d[i]   = src_b_q[i+1];
          dst_d[i]     = dst_q[i+1];
          rdy_a_d[i]   = wk_rdy_a[i+1];
          rdy_b_d[i]   = wk_rdy_b[i+1];
          payload_d[i] = payload_q[i+1];
        end
      end
      valid_d[DEPTH-1] = 1'b0;
    end
    if (accept) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_pos == CW'(i)) begin
          valid_d[i]   = 1'b1;
          src_a_d[i]   = bus.alloc_src_a;
          src_b_d[i]   = bus.alloc_src_b;
          dst_d[i]     = bus.alloc_dst;
          rdy_a_d[i]   = new_rdy_a;
          rdy_b_d[i]   = new_rdy_b;
          payload_d[i] = bus.alloc_payload;
        end
      end
    end
    count_d = count_q - CW'(fire) + CW'(accept);
    if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) valid_d[i] = 1'b0;
      count_d = '0;
    end
  end

  // Issue register: frozen under stall, cleared by flush, otherwise loaded from the selected slot
  always_comb begin
    issue_valid_d   = issue_valid_q;
    issue_src_a_d   = issue_src_a_q;
    issue_src_b_d   = issue_src_b_q;
    issue_dst_d     = issue_dst_q;
    issue_payload_d = issue_payload_q;
    if (bus.flush) begin
      issue_valid_d = 1'b0;
    end else if (!bus.issue_stall) begin
      issue_valid_d = sel_found;
      if (sel_found) begin
        issue_src_a_d   = src_a_q[sel_idx];
        issue_src_b_d   = src_b_q[sel_idx];
        issue_dst_d     = dst_q[sel_idx];
        issue_payload_d = payload_q[sel_idx];
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i]   <= 1'b0;
        src_a_q[i]   <= '0;
        src_b_q[i]   <= '0;
        dst_q[i]     <= '0;
        rdy_a_q[i]   <= 1'b0;
        rdy_b_q[i]   <= 1'b0;
        payload_q[i] <= '0;
      end
      count_q         <= '0;
      issue_valid_q   <= 1'b0;
      issue_src_a_q   <= '0;
      issue_src_b_q   <= '0;
      issue_dst_q     <= '0;
      issue_payload_q <= '0;
    end else begin
      valid_q         <= valid_d;
      src_a_q         <= src_a_d;
      src_b_q         <= src_b_d;
      dst_q           <= dst_d;
      rdy_a_q         <= rdy_a_d;
      rdy_b_q         <= rdy_b_d;
      payload_q       <= payload_d;
      count_q         <= count_d;
      issue_valid_q   <= issue_valid_d;
      issue_src_a_q   <= issue_src_a_d;
      issue_src_b_q   <= issue_src_b_d;
      issue_dst_q     <= issue_dst_d;
      issue_payload_q <= issue_payload_d;
    end
  end

  assign bus.issue_halt    = halt;
  assign bus.count         = count_q;
  assign bus.issue_valid   = issue_valid_q;
  assign bus.issue_src_a   = issue_src_a_q;
  assign bus.issue_src_b   = issue_src_b_q;
  assign bus.issue_dst     = issue_dst_q;
  assign bus.issue_payload = issue_payload_q;
endmodule

// File: tb/tb_issue_queue.sv
// tb/tb_issue_queue.sv - self-checking bench for issue_queue with a queue-based reference model
module tb_issue_queue;
  localparam int DEPTH = 8;
  localparam int TAG_W = 6;
  localparam int PW    = 104;
`ifdef ISSUE_FAST_WAKEUP_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  typedef struct {
    logic [TAG_W-1:0] a;
    bit               ra;
    logic [TAG_W-1:0] b;
    bit               rb;
    logic [TAG_W-1:0] d;
    logic [PW-1:0]    p;
  } ent_t;

  logic CLK;
  logic RESET;
  int   n_cmp  = 0;
  int   n_fail = 0;
  ent_t mq[$];
  bit   m_iv;
  ent_t m_iss;

  issue_queue_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PAYLOAD_W(PW)) bus ();
  issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PAYLOAD_W(PW)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic bit woken(input logic [TAG_W-1:0] tag);
    return bus.wake_valid && bus.wake_tag == tag;
  endfunction

  // Reference: oldest ready entry leaves the queue, survivors see the wake, new entry appended
  task automatic model_step();
    int   pre;
    int   found;
    ent_t e;
    pre   = mq.size();
    found = -1;
    if (bus.flush) begin
      mq.delete();
      m_iv = 1'b0;
      return;
    end
    if (!bus.issue_stall) begin
      for (int i = 0; i < mq.size(); i++)
        if (found < 0 && (mq[i].ra || (FAST && woken(mq[i].a))) && (mq[i].rb || (FAST && woken(mq[i].b))))
          found = i;
      if (found >= 0) begin
        m_iv  = 1'b1;
        m_iss = mq[found];
        mq.delete(found);
      end else begin
        m_iv = 1'b0;
      end
    end
    for (int i = 0; i < mq.size(); i++) begin
      if (woken(mq[i].a)) mq[i].ra = 1'b1;
      if (woken(mq[i].b)) mq[i].rb = 1'b1;
    end
    if (bus.alloc_valid && pre != DEPTH) begin
      e.a  = bus.alloc_src_a;
      e.b  = bus.alloc_src_b;
      e.d  = bus.alloc_dst;
      e.p  = bus.alloc_payload;
      e.ra = !bus.alloc_src_a_busy || woken(e.a) || e.a == 0;
      e.rb = !bus.alloc_src_b_busy || woken(e.b) || e.b == 0;
      mq.push_back(e);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_iv = 1'b0;
  endtask

  task automatic step();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alloc_valid      = 1'b0;
    bus.alloc_src_a      = '0;
    bus.alloc_src_a_busy = 1'b0;
    bus.alloc_src_b      = '0;
    bus.alloc_src_b_busy = 1'b0;
    bus.alloc_dst        = '0;
    bus.alloc_payload    = '0;
    bus.wake_valid       = 1'b0;
    bus.wake_tag         = '0;
    bus.issue_stall      = 1'b0;
    bus.flush            = 1'b0;
  endtask

  task automatic set_alloc(input int a, input bit ab, input int b, input bit bb, input int d);
    bus.alloc_valid      = 1'b1;
    bus.alloc_src_a      = TAG_W'(a);
    bus.alloc_src_a_busy = ab;
    bus.alloc_src_b      = TAG_W'(b);
    bus.alloc_src_b_busy = bb;
    bus.alloc_dst        = TAG_W'(d);
    bus.alloc_payload    = PW'({$urandom(), $urandom(), $urandom(), $urandom()});
  endtask

  task automatic test_reset();
    idle_inputs();
    RESET = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    n_cmp++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    n_cmp++; if (bus.issue_halt !== 1'b0) begin n_fail++; $display("FAIL reset_halt: got %b want 0", bus.issue_halt); end
    n_cmp++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.issue_valid); end
    n_cmp++;
    if ({bus.issue_src_a, bus.issue_src_b, bus.issue_dst} !== 18'd0 || bus.issue_payload !== '0) begin
      n_fail++; $display("FAIL reset_fields: got a=%0d b=%0d d=%0d p=%h want all 0",
                         bus.issue_src_a, bus.issue_src_b, bus.issue_dst, bus.issue_payload);
    end
    #3 RESET = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_basic_issue();
    logic [PW-1:0] p;
    set_alloc(3, 0, 4, 0, 5);
    p = bus.alloc_payload;
    step();
    n_cmp++; if (bus.issue_valid !== 1'b0 || bus.count !== 4'd1) begin n_fail++; $display("FAIL basic_e1: got v=%b cnt=%0d want v=0 cnt=1", bus.issue_valid, bus.count); end
    idle_inputs();
    step();
    n_cmp++; if (bus.issue_valid !== 1'b1 || bus.issue_dst !== 6'd5) begin n_fail++; $display("FAIL basic_issue: got v=%b dst=%0d want v=1 dst=5", bus.issue_valid, bus.issue_dst); end
    n_cmp++; if (bus.issue_payload !== p || bus.count !== 4'd0) begin n_fail++; $display("FAIL basic_payload_count: got p=%h cnt=%0d want p=%h cnt=0", bus.issue_payload, bus.count, p); end
    step();
  endtask

  task automatic test_wake_order();
    set_alloc(9, 1, 0, 1, 10);
    step();
    set_alloc(1, 0, 2, 0, 11);
    step();
    idle_inputs();
    step();
    n_cmp++; if (bus.issue_valid !== 1'b1 || bus.issue_dst !== 6'd11 || bus.count !== 4'd1) begin
      n_fail++; $display("FAIL order_younger_first: got v=%b dst=%0d cnt=%0d want v=1 dst=11 cnt=1", bus.issue_valid, bus.issue_dst, bus.count); end
    bus.wake_valid = 1'b1;
    bus.wake_tag   = 6'd9;
    step();
    idle_inputs();
`ifdef ISSUE_FAST_WAKEUP_EN
    n_cmp++; if (bus.issue_valid !== 1'b1 || bus.issue_dst !== 6'd10) begin n_fail++; $display("FAIL wake_fast: got v=%b dst=%0d want v=1 dst=10", bus.issue_valid, bus.issue_dst); end
`else
    n_cmp++; if (bus.issue_valid !== 1'b0 || bus.count !== 4'd1) begin n_fail++; $display("FAIL wake_edge_k: got v=%b cnt=%0d want v=0 cnt=1", bus.issue_valid, bus.count); end
    step();
    n_cmp++; if (bus.issue_valid !== 1'b1 || bus.issue_dst !== 6'd10) begin n_fail++; $display("FAIL wake_edge_k1: got v=%b dst=%0d want v=1 dst=10", bus.issue_valid, bus.issue_dst); end
`endif
    n_cmp++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL wake_drained: got cnt=%0d want 0", bus.count); end
    step();
  endtask

  task automatic test_alloc_wake_same();
    set_alloc(12, 1, 13, 0, 14);
    bus.wake_valid = 1'b1;
    bus.wake_tag   = 6'd12;
    step();
    idle_inputs();
    n_cmp++; if (bus.count !== 4'd1 || bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL capture_e1: got cnt=%0d v=%b want cnt=1 v=0", bus.count, bus.issue_valid); end
    step();
    n_cmp++; if (bus.issue_valid !== 1'b1 || bus.issue_dst !== 6'd14) begin n_fail++; $display("FAIL capture_issue: got v=%b dst=%0d want v=1 dst=14", bus.issue_valid, bus.issue_dst); end
    step();
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin
      set_alloc(20 + i, 1, 0, 1, 30 + i);
      step();
    end
    n_cmp++; if (bus.count !== 4'd8 || bus.issue_halt !== 1'b1) begin n_fail++; $display("FAIL full: got cnt=%0d halt=%b want cnt=8 halt=1", bus.count, bus.issue_halt); end
    set_alloc(1, 0, 2, 0, 63);
    step();
    n_cmp++; if (bus.count !== 4'd8 || bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL full_ignore: got cnt=%0d v=%b want cnt=8 v=0", bus.count, bus.issue_valid); end
    idle_inputs();
    bus.wake_valid = 1'b1;
    bus.wake_tag   = 6'd23;
    step();
    idle_inputs();
`ifndef ISSUE_FAST_WAKEUP_EN
    n_cmp++; if (bus.count !== 4'd8 || bus.issue_halt !== 1'b1) begin n_fail++; $display("FAIL full_wake_k: got cnt=%0d halt=%b want cnt=8 halt=1", bus.count, bus.issue_halt); end
    step();
`endif
    n_cmp++; if (bus.issue_valid !== 1'b1 || bus.issue_dst !== 6'd33) begin n_fail++; $display("FAIL full_issue: got v=%b dst=%0d want v=1 dst=33", bus.issue_valid, bus.issue_dst); end
    n_cmp++; if (bus.count !== 4'd7 || bus.issue_halt !== 1'b0) begin n_fail++; $display("FAIL full_drop: got cnt=%0d halt=%b want cnt=7 halt=0", bus.count, bus.issue_halt); end
    bus.flush = 1'b1;
    step();
    idle_inputs();
    n_cmp++; if (bus.count !== 4'd0 || bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL full_flush: got cnt=%0d v=%b want 0 0", bus.count, bus.issue_valid); end
  endtask

  task automatic test_stall_flush();
    logic [PW-1:0] p;
    set_alloc(1, 0, 2, 0, 40);
    p = bus.alloc_payload;
    step();
    set_alloc(1, 0, 2, 0, 41);
    step();
    n_cmp++; if (bus.issue_valid !== 1'b1 || bus.issue_dst !== 6'd40 || bus.count !== 4'd1) begin
      n_fail++; $display("FAIL stall_pre: got v=%b dst=%0d cnt=%0d want 1 40 1", bus.issue_valid, bus.issue_dst, bus.count); end
    set_alloc(3, 0, 4, 0, 42);
    bus.issue_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      bus.alloc_valid = 1'b0;
      n_cmp++;
      if (bus.issue_valid !== 1'b1 || bus.issue_dst !== 6'd40 || bus.issue_payload !== p || bus.count !== 4'd2) begin
        n_fail++; $display("FAIL stall_hold%0d: got v=%b dst=%0d cnt=%0d want 1 40 2", c, bus.issue_valid, bus.issue_dst, bus.count); end
    end
    set_alloc(5, 0, 6, 0, 43);
    bus.flush = 1'b1;
    step();
    idle_inputs();
    n_cmp++; if (bus.count !== 4'd0 || bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL stall_flush: got cnt=%0d v=%b want 0 0", bus.count, bus.issue_valid); end
    step();
    n_cmp++; if (bus.count !== 4'd0 || bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL flush_discard: got cnt=%0d v=%b want 0 0", bus.count, bus.issue_valid); end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) begin
      set_alloc(50 + i, 1, 0, 0, 20 + i);
      step();
    end
    idle_inputs();
    n_cmp++; if (bus.count !== 4'd3) begin n_fail++; $display("FAIL mid_pre: got cnt=%0d want 3", bus.count); end
    #2 RESET = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (bus.count !== 4'd0 || bus.issue_valid !== 1'b0 || bus.issue_halt !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: got cnt=%0d v=%b halt=%b want 0 0 0", bus.count, bus.issue_valid, bus.issue_halt); end
    #2 RESET = 1'b1;
    set_alloc(1, 0, 2, 0, 7);
    step();
    idle_inputs();
    n_cmp++; if (bus.count !== 4'd1) begin n_fail++; $display("FAIL mid_first_alloc: got cnt=%0d want 1", bus.count); end
    step();
    n_cmp++; if (bus.issue_valid !== 1'b1 || bus.issue_dst !== 6'd7) begin n_fail++; $display("FAIL mid_issue: got v=%b dst=%0d want 1 7", bus.issue_valid, bus.issue_dst); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      bus.alloc_valid      = ($urandom_range(0, 9) < 6);
      bus.alloc_src_a      = TAG_W'($urandom_range(0, 7));
      bus.alloc_src_a_busy = ($urandom_range(0, 9) < 7);
      bus.alloc_src_b      = TAG_W'($urandom_range(0, 7));
      bus.alloc_src_b_busy = ($urandom_range(0, 9) < 7);
      bus.alloc_dst        = TAG_W'($urandom_range(0, 63));
      bus.alloc_payload    = PW'({$urandom(), $urandom(), $urandom(), $urandom()});
      bus.wake_valid       = ($urandom_range(0, 2) == 0);
      bus.wake_tag         = TAG_W'($urandom_range(1, 7));
      bus.issue_stall      = ($urandom_range(0, 4) == 0);
      bus.flush            = ($urandom_range(0, 59) == 0);
      step();
      n_cmp++; if (bus.count !== 4'(mq.size())) begin n_fail++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, bus.count, mq.size()); end
      n_cmp++; if (bus.issue_halt !== (mq.size() == DEPTH)) begin n_fail++; $display("FAIL rnd_halt c%0d: got %b want %b", c, bus.issue_halt, mq.size() == DEPTH); end
      n_cmp++; if (bus.issue_valid !== m_iv) begin n_fail++; $display("FAIL rnd_valid c%0d: got %b want %b", c, bus.issue_valid, m_iv); end
      if (m_iv) begin
        n_cmp++;
        if ({bus.issue_src_a, bus.issue_src_b, bus.issue_dst} !== {m_iss.a, m_iss.b, m_iss.d} || bus.issue_payload !== m_iss.p) begin
          n_fail++; $display("FAIL rnd_fields c%0d: got a=%0d b=%0d d=%0d want a=%0d b=%0d d=%0d",
                             c, bus.issue_src_a, bus.issue_src_b, bus.issue_dst, m_iss.a, m_iss.b, m_iss.d);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic_issue();
    test_wake_order();
    test_alloc_wake_same();
    test_full();
    test_stall_flush();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
